// File: rtl/clk_div_pkg.sv
// Shared constants for the runtime-programmable clock divider: state encoding
// and parameter defaults used by the controller and its counter core.
package clk_div_pkg;

   localparam int CNT_W_DEF        = 16;
   localparam int DEFAULT_HALF_DEF = 8;

   typedef logic [1:0] state_t;

   localparam state_t STOPPED   = 2'd0;
   localparam state_t RUNNING   = 2'd1;
   localparam state_t SWITCHING = 2'd2;
   localparam state_t STOPPING  = 2'd3;

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter and divided-clock toggle register with edge ticks.
// Holds the active half-period; the controller decides when to load, run or clear.
module clk_div_core
   import clk_div_pkg::*;
#(
   parameter int CNT_W        = CNT_W_DEF,
   parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_half,
   input  logic [CNT_W-1:0] half_in,
   input  logic             enable,
   input  logic             clear,
   output logic             terminal,
   output logic             div_clock,
   output logic             tick_rise,
   output logic             tick_fall
);

   localparam logic [CNT_W-1:0] HALF_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] half_q, half_d;
   logic             div_q, div_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   // active half is always >= 1, so the subtraction never wraps
   assign terminal = (cnt_q == (half_q - HALF_ONE));

   always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      half_d = load_half ? half_in : half_q;
      if (clear) begin
         cnt_d = '0;
         div_d = 1'b0;
      end else if (enable) begin
         if (terminal) begin
            cnt_d = '0;
            div_d = ~div_q;
         end else begin
            cnt_d = cnt_q + HALF_ONE;
         end
      end
      // ticks follow the actual register change, so a clear never fakes a rise
      rise_d = div_d & ~div_q;
      fall_d = ~div_d & div_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         half_q <= CNT_W'(DEFAULT_HALF);
         div_q  <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         half_q <= half_d;
         div_q  <= div_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign div_clock = div_q;
   assign tick_rise = rise_q;
   assign tick_fall = fall_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock-divider controller: sequences start, stop and glitch-free ratio changes
// of a square-wave divided clock, with a valid/ready port for the half-period.
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int CNT_W        = CNT_W_DEF,
   parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             run,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_half,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             div_clock,
   output logic             tick_rise,
   output logic             tick_fall,
   output logic             busy
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] pending_q, pending_d;
   logic             cfg_ready_q, cfg_ready_d;
   logic             cfg_err_q, cfg_err_d;
   logic             accept, cfg_ok;
   logic             load_half, enable, clear, terminal;
   logic [CNT_W-1:0] half_in;

   assign accept = cfg_valid & cfg_ready_q;
   assign cfg_ok = accept & (cfg_half != '0);

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      load_half = 1'b0;
      half_in   = cfg_half;
      case (state_q)
         STOPPED: begin
            load_half = cfg_ok;
            if (run) state_d = RUNNING;
         end
         RUNNING: begin
            if (cfg_ok) begin
               pending_d = cfg_half;
               state_d   = SWITCHING;
            end else if (!run) begin
               // a high phase ending this very cycle falls now, so stop directly
               state_d = (div_clock && !terminal) ? STOPPING : STOPPED;
            end
         end
         SWITCHING: begin
            if (terminal) begin
               load_half = 1'b1;
               half_in   = pending_q;
               state_d   = RUNNING;
            end
         end
         STOPPING: begin
            if (terminal) state_d = STOPPED;
         end
         default: state_d = STOPPED;
      endcase
   end

   assign cfg_err_d   = accept & (cfg_half == '0);
   assign cfg_ready_d = (state_d == STOPPED) || (state_d == RUNNING);
   assign enable      = (state_q != STOPPED);
   assign clear       = (state_d == STOPPED);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= STOPPED;
         pending_q   <= '0;
         cfg_ready_q <= 1'b1;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         cfg_ready_q <= cfg_ready_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   clk_div_core #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
   ) u_core (
      .clock     (clock),
      .reset     (reset),
      .load_half (load_half),
      .half_in   (half_in),
      .enable    (enable),
      .clear     (clear),
      .terminal  (terminal),
      .div_clock (div_clock),
      .tick_rise (tick_rise),
      .tick_fall (tick_fall)
   );

   assign cfg_ready = cfg_ready_q;
   assign cfg_err   = cfg_err_q;
   assign busy      = (state_q != STOPPED);

endmodule
